// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: 640x480@60 raster constants and small helpers shared by the VGA timing block
package vga_pkg;
  localparam int H_VIS_D  = 640;
  localparam int H_FP_D   = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D   = 48;
  localparam int V_VIS_D  = 480;
  localparam int V_FP_D   = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D   = 33;
  localparam int H_TOTAL_D  = H_VIS_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D  = V_VIS_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int HS_START_D = H_VIS_D + H_FP_D;
  localparam int HS_END_D   = HS_START_D + H_SYNC_D;
  localparam int VS_START_D = V_VIS_D + V_FP_D;
  localparam int VS_END_D   = VS_START_D + V_SYNC_D;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic in_win(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster coordinates, strobes, sync and colour between the timing generator and its consumers
interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int XW      = cw(H_TOTAL_D),
  parameter int YW      = cw(V_TOTAL_D),
  parameter int COLOR_W = 4
);
  logic [3*COLOR_W-1:0] rgb_in;
  logic                 pix_ce;
  logic [XW-1:0]        pixel_x;
  logic [YW-1:0]        pixel_y;
  logic                 de_req;
  logic                 line_start;
  logic                 frame_start;
  logic                 HS;
  logic                 VS;
  logic [COLOR_W-1:0]   R;
  logic [COLOR_W-1:0]   G;
  logic [COLOR_W-1:0]   B;
  modport master (
    input  rgb_in,
    output pix_ce, pixel_x, pixel_y, de_req, line_start, frame_start, HS, VS, R, G, B
  );
  modport slave (
    output rgb_in,
    input  pix_ce, pixel_x, pixel_y, de_req, line_start, frame_start, HS, VS, R, G, B
  );
endinterface

// File: rtl/vga_timing_gen_pixel_ce_gen.sv
// pixel_ce_gen: divides the system clock into a one-clock pixel advance strobe
module pixel_ce_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic ce
);
  localparam int DW = cw(CLK_DIV);
  logic [DW-1:0] div;
  logic [DW-1:0] div_n;
  always_comb div_n = (int'(div) == CLK_DIV - 1) ? '0 : div + 1'b1;
  // ce is registered so it reads 0 in the cycle after reset even when CLK_DIV is 1
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      ce  <= 1'b0;
    end else begin
      div <= div_n;
      ce  <= int'(div_n) == CLK_DIV - 1;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters with sync and colour registered one pixel behind x/y
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = H_VIS_D,
  parameter int H_FP    = H_FP_D,
  parameter int H_SYNC  = H_SYNC_D,
  parameter int H_BP    = H_BP_D,
  parameter int V_VIS   = V_VIS_D,
  parameter int V_FP    = V_FP_D,
  parameter int V_SYNC  = V_SYNC_D,
  parameter int V_BP    = V_BP_D,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int COLOR_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  vga_timing_gen_if.master v
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_S    = H_VIS + H_FP;
  localparam int VS_S    = V_VIS + V_FP;
  localparam int XW      = cw(H_TOTAL);
  localparam int YW      = cw(V_TOTAL);
  logic                 ce;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic                 x_last;
  logic                 y_last;
  logic                 de;
  logic                 hs_act;
  logic                 vs_act;
  logic [3*COLOR_W-1:0] rgb_q;
  pixel_ce_gen #(.CLK_DIV(CLK_DIV)) u_ce (
    .clk  (clk),
    .reset(reset),
    .ce   (ce)
  );
  always_comb begin
    x_last = int'(x) == H_TOTAL - 1;
    y_last = int'(y) == V_TOTAL - 1;
    de     = (int'(x) < H_VIS) && (int'(y) < V_VIS);
    hs_act = in_win(int'(x), HS_S, HS_S + H_SYNC);
    vs_act = in_win(int'(y), VS_S, VS_S + V_SYNC);
    rgb_q  = de ? v.rgb_in : '0;
  end
  // Decode uses the pre-advance x/y, so HS/VS/RGB trail the coordinates by exactly one pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      x                   <= '0;
      y                   <= '0;
      v.HS                <= ~HS_POL;
      v.VS                <= ~VS_POL;
      {v.R, v.G, v.B}     <= '0;
      v.line_start        <= 1'b0;
      v.frame_start       <= 1'b0;
    end else begin
      v.line_start  <= ce && x_last;
      v.frame_start <= ce && x_last && y_last;
      if (ce) begin
        x               <= x_last ? '0 : x + 1'b1;
        y               <= x_last ? (y_last ? '0 : y + 1'b1) : y;
        v.HS            <= hs_act ? HS_POL : ~HS_POL;
        v.VS            <= vs_act ? VS_POL : ~VS_POL;
        {v.R, v.G, v.B} <= rgb_q;
      end
    end
  end
  assign v.pix_ce  = ce;
  assign v.pixel_x = x;
  assign v.pixel_y = y;
  assign v.de_req  = de;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default 640x480 timing and a tiny 8x6 raster with inverted polarity
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(10), .YW(10), .COLOR_W(4)) ia ();
  vga_timing_gen_if #(.XW(3), .YW(3), .COLOR_W(4)) ib ();

  vga_timing_gen dut_a (
    .clk  (clk),
    .reset(rst_a),
    .v    (ia)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4)
  ) dut_b (
    .clk  (clk),
    .reset(rst_b),
    .v    (ib)
  );

  typedef struct {int i, x, y, hs, vs, de, ls, fs, rgb;} vec_t;
  vec_t tab [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ce_cnt = 0, bad_ce = 0, last_ce = -1, hs_low = 0, falls = 0;
    int first_fall = -1, fall_x = -1, fall_gap = -1, rgb_on = 0, rgb_bad = 0;
    int ls_a = 0, ls_x = -1, fi = -1, fx = -1, k = 0;
    int fs_cnt = 0, ls_cnt = 0, vs_cnt = 0, hs_cnt = 0, fs_no_ls = 0;
    int ls_double = 0, fs_gap_bad = 0, last_fs = -1, over = 0, ce_low = 0;
    logic prev_hs = 1'b1;
    logic prev_ls = 1'b0;
    tab = '{
      '{0, 0, 0, 0, 0, 1, 0, 0, 0},
      '{1, 1, 0, 0, 0, 1, 0, 0, 'h5A3},
      '{4, 4, 0, 0, 0, 0, 0, 0, 'h5A3},
      '{5, 5, 0, 0, 0, 0, 0, 0, 0},
      '{6, 6, 0, 1, 0, 0, 0, 0, 0},
      '{7, 7, 0, 1, 0, 0, 0, 0, 0},
      '{8, 0, 1, 0, 0, 1, 1, 0, 0},
      '{9, 1, 1, 0, 0, 1, 0, 0, 'h5A3},
      '{24, 0, 3, 0, 0, 0, 1, 0, 0},
      '{25, 1, 3, 0, 0, 0, 0, 0, 0},
      '{32, 0, 4, 0, 0, 0, 1, 0, 0},
      '{33, 1, 4, 0, 1, 0, 0, 0, 0},
      '{40, 0, 5, 0, 1, 0, 1, 0, 0},
      '{41, 1, 5, 0, 0, 0, 0, 0, 0},
      '{48, 0, 0, 0, 0, 1, 1, 1, 0},
      '{49, 1, 0, 0, 0, 1, 0, 0, 'h5A3}
    };
    ia.rgb_in = 12'hF0A;
    ib.rgb_in = 12'h5A3;
    repeat (3) tick();
    chk("a_rst_x", ia.pixel_x, 0);
    chk("a_rst_y", ia.pixel_y, 0);
    chk("a_rst_ce", ia.pix_ce, 0);
    chk("a_rst_hs", ia.HS, 1);
    chk("a_rst_vs", ia.VS, 1);
    chk("a_rst_rgb", {ia.R, ia.G, ia.B}, 0);
    chk("a_rst_ls", ia.line_start, 0);
    chk("a_rst_fs", ia.frame_start, 0);
    chk("a_rst_de", ia.de_req, 1);
    chk("b_rst_hs", ib.HS, 0);
    chk("b_rst_vs", ib.VS, 0);
    chk("b_rst_ce", ib.pix_ce, 0);
    rst_a = 1'b0;
    for (int i = 0; i < 6399; i++) begin
      tick();
      if (ia.pix_ce) begin
        ce_cnt++;
        if (last_ce >= 0 && i - last_ce != 4) bad_ce++;
        last_ce = i;
      end
      if (!ia.HS) hs_low++;
      if (prev_hs && !ia.HS) begin
        falls++;
        if (falls == 1) begin
          first_fall = i;
          fall_x = int'(ia.pixel_x);
        end else fall_gap = i - first_fall;
      end
      prev_hs = ia.HS;
      if ({ia.R, ia.G, ia.B} == 12'hF0A) rgb_on++;
      else if ({ia.R, ia.G, ia.B} != 12'h000) rgb_bad++;
      if (ia.line_start) begin
        ls_a++;
        ls_x = int'(ia.pixel_x);
      end
    end
    chk("a_ce_count", ce_cnt, 1600);
    chk("a_ce_spacing", bad_ce, 0);
    chk("a_hs_low_clks", hs_low, 768);
    chk("a_hs_falls", falls, 2);
    chk("a_hs_first_fall", first_fall, 2627);
    chk("a_hs_fall_x", fall_x, 657);
    chk("a_hs_period", fall_gap, 3200);
    chk("a_rgb_on_clks", rgb_on, 5120);
    chk("a_rgb_other", rgb_bad, 0);
    chk("a_ls_count", ls_a, 1);
    chk("a_ls_x", ls_x, 0);
    for (int n = 0; n < 4000 && int'(ia.pixel_x) != 300; n++) tick();
    chk("a_reach_x300", ia.pixel_x, 300);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("a_mid_rst_x", ia.pixel_x, 0);
    chk("a_mid_rst_y", ia.pixel_y, 0);
    chk("a_mid_rst_hs", ia.HS, 1);
    chk("a_mid_rst_vs", ia.VS, 1);
    chk("a_mid_rst_rgb", {ia.R, ia.G, ia.B}, 0);
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!ia.HS) begin
        fi = n;
        fx = int'(ia.pixel_x);
        break;
      end
    end
    chk("a_resume_fall", fi, 2627);
    chk("a_resume_fall_x", fx, 657);
    rst_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (k < 16 && tab[k].i == i) begin
        chk($sformatf("b_x@%0d", i), ib.pixel_x, tab[k].x);
        chk($sformatf("b_y@%0d", i), ib.pixel_y, tab[k].y);
        chk($sformatf("b_hs@%0d", i), ib.HS, tab[k].hs);
        chk($sformatf("b_vs@%0d", i), ib.VS, tab[k].vs);
        chk($sformatf("b_de@%0d", i), ib.de_req, tab[k].de);
        chk($sformatf("b_ls@%0d", i), ib.line_start, tab[k].ls);
        chk($sformatf("b_fs@%0d", i), ib.frame_start, tab[k].fs);
        chk($sformatf("b_rgb@%0d", i), {ib.R, ib.G, ib.B}, tab[k].rgb);
        k++;
      end
      if (!ib.pix_ce) ce_low++;
      if (ib.HS) hs_cnt++;
      if (ib.VS) vs_cnt++;
      if (ib.line_start) ls_cnt++;
      if (ib.line_start && prev_ls) ls_double++;
      prev_ls = ib.line_start;
      if (ib.frame_start) begin
        fs_cnt++;
        if (last_fs >= 0 && i - last_fs != 48) fs_gap_bad++;
        last_fs = i;
        if (!ib.line_start) fs_no_ls++;
      end
      if (int'(ib.pixel_x) > 7 || int'(ib.pixel_y) > 5) over++;
    end
    chk("b_table_done", k, 16);
    chk("b_ce_low", ce_low, 0);
    chk("b_hs_clks", hs_cnt, 50);
    chk("b_vs_clks", vs_cnt, 32);
    chk("b_ls_count", ls_cnt, 24);
    chk("b_ls_double", ls_double, 0);
    chk("b_fs_count", fs_cnt, 4);
    chk("b_fs_gap", fs_gap_bad, 0);
    chk("b_fs_no_ls", fs_no_ls, 0);
    chk("b_range", over, 0);
    for (int n = 0; n < 60 && !(int'(ib.pixel_x) == 6 && int'(ib.pixel_y) == 2); n++) tick();
    chk("b_reach_x6y2", {ib.pixel_y, ib.pixel_x}, {3'd2, 3'd6});
    chk("b_hs_before_rst", ib.HS, 1);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("b_mid_rst_x", ib.pixel_x, 0);
    chk("b_mid_rst_y", ib.pixel_y, 0);
    chk("b_mid_rst_hs", ib.HS, 0);
    chk("b_mid_rst_vs", ib.VS, 0);
    chk("b_mid_rst_rgb", {ib.R, ib.G, ib.B}, 0);
    chk("b_mid_rst_ls", ib.line_start, 0);
    chk("b_mid_rst_fs", ib.frame_start, 0);
    for (int i = 0; i <= 48; i++) begin
      tick();
      if (i == 5) chk("b_resume_hs5", ib.HS, 0);
      if (i == 6) chk("b_resume_hs6", ib.HS, 1);
      if (i == 47) chk("b_resume_fs47", ib.frame_start, 0);
      if (i == 48) chk("b_resume_fs48", ib.frame_start, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
